// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding the seven-segment display path.
// One value is captured on start, converted over IN_WIDTH shift cycles, and the result is held until the next conversion.
module bcd_converter_seq #(
    parameter int IN_WIDTH = 32,
    parameter int DIGITS   = 4,
    parameter bit SIGNED   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int CMP_W = (IN_WIDTH > 64) ? IN_WIDTH : 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Largest value representable in DIGITS decimal digits, i.e. 10^DIGITS - 1.
    function automatic logic [CMP_W-1:0] max_bcd_value(input int digits);
        logic [CMP_W-1:0] acc;
        acc = {{(CMP_W-1){1'b0}}, 1'b1};
        for (int i = 0; i < digits; i++) begin
            acc = acc * {{(CMP_W-4){1'b0}}, 4'd10};
        end
        return acc - {{(CMP_W-1){1'b0}}, 1'b1};
    endfunction

    localparam logic [CMP_W-1:0] MAX_VAL    = max_bcd_value(DIGITS);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0]    ALL_NINES  = {DIGITS{4'd9}};

    logic [1:0]          state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [BW-1:0]       bcd_work_r;
    logic [IN_WIDTH-1:0] bin_work_r;
    logic                neg_work_r;
    logic                ovf_work_r;
    logic [BW-1:0]       bcd_r;
    logic                neg_r;
    logic                ovf_r;
    logic                busy_r;
    logic                done_r;

    logic [IN_WIDTH-1:0] mag_s;
    logic                neg_in_s;
    logic                ovf_in_s;
    logic [BW-1:0]       adj_s;
    logic [BW-1:0]       shift_bcd_s;
    logic [IN_WIDTH-1:0] shift_bin_s;

    // Magnitude, sign and overflow of the value presented for capture.
    always_comb begin
        mag_s    = bin_in;
        neg_in_s = 1'b0;
        if (SIGNED && bin_in[IN_WIDTH-1]) begin
            mag_s    = ~bin_in + {{(IN_WIDTH-1){1'b0}}, 1'b1};
            neg_in_s = 1'b1;
        end else begin
            mag_s    = bin_in;
            neg_in_s = 1'b0;
        end
        ovf_in_s = (CMP_W'(mag_s) > MAX_VAL);
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift the pair left.
    always_comb begin
        adj_s = bcd_work_r;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_work_r[4*d +: 4] >= 4'd5) begin
                adj_s[4*d +: 4] = bcd_work_r[4*d +: 4] + 4'd3;
            end else begin
                adj_s[4*d +: 4] = bcd_work_r[4*d +: 4];
            end
        end
        shift_bcd_s = {adj_s[BW-2:0], bin_work_r[IN_WIDTH-1]};
        shift_bin_s = {bin_work_r[IN_WIDTH-2:0], 1'b0};
    end

    // Conversion FSM; the result is registered on the last shift so it is visible during DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            bcd_work_r <= {BW{1'b0}};
            bin_work_r <= {IN_WIDTH{1'b0}};
            neg_work_r <= 1'b0;
            ovf_work_r <= 1'b0;
            bcd_r      <= {BW{1'b0}};
            neg_r      <= 1'b0;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        bin_work_r <= mag_s;
                        bcd_work_r <= {BW{1'b0}};
                        neg_work_r <= neg_in_s;
                        ovf_work_r <= ovf_in_s;
                        cnt_r      <= {CNT_W{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= ST_SHIFT;
                    end else begin
                        busy_r     <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    bcd_work_r <= shift_bcd_s;
                    bin_work_r <= shift_bin_s;
                    if (cnt_r == LAST_SHIFT) begin
                        // Overflowed conversions still shift for uniform latency, but the result is saturated.
                        bcd_r   <= ovf_work_r ? ALL_NINES : shift_bcd_s;
                        neg_r   <= neg_work_r;
                        ovf_r   <= ovf_work_r;
                        done_r  <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd  = bcd_r;
    assign neg  = neg_r;
    assign ovf  = ovf_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
